// File: rtl/phy_speed_poller_pkg.sv
// Shared definitions for the PHY speed poller: FSM states, MDIO frame
// layout and the PHY-specific status register bit map.
package phy_poller_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_RST,
    ST_STARTUP,
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_TA,
    ST_DATA,
    ST_DONE,
    ST_HOLD
  } state_e;

  // MDIO clause-22 read frame field lengths (in MDC periods)
  localparam int PRE_LEN    = 32;
  localparam int CMD_LEN    = 14;
  localparam int TA_LEN     = 2;
  localparam int DATA_LEN   = 16;
  localparam int FRAME_LEN  = PRE_LEN + CMD_LEN + TA_LEN + DATA_LEN;
  localparam int CMD_END    = PRE_LEN + CMD_LEN;   // first TA bit index
  localparam int DATA_START = CMD_END + TA_LEN;    // first data bit index

  // status register bit positions
  localparam int SPD_HI   = 15;
  localparam int SPD_LO   = 14;
  localparam int DPX      = 13;
  localparam int RESOLVED = 11;
  localparam int LINK     = 10;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  // ST, OP, PHYAD, REGAD as shifted out MSB first
  function automatic logic [CMD_LEN-1:0] rd_cmd(input logic [4:0] phy_a,
                                                 input logic [4:0] reg_a);
    return {MDIO_ST, MDIO_OP_RD, phy_a, reg_a};
  endfunction

endpackage

// File: rtl/phy_speed_poller_if.sv
// MDIO pins plus the bus-hold handshake between poller and pad mux/MAC side.
interface phy_speed_poller_if;
  logic mdc;
  logic mdio_in;
  logic mdio_out;
  logic mdio_oen;
  logic hold_req;
  logic hold_ack;

  modport master (output mdc, mdio_out, mdio_oen, hold_ack,
                  input  mdio_in, hold_req);
  modport slave  (input  mdc, mdio_out, mdio_oen, hold_ack,
                  output mdio_in, hold_req);
endinterface

// File: rtl/phy_speed_poller_mdio_frame_shifter.sv
// One MDIO read frame: MDC divider, bit counter, command shift-out and
// turnaround/data capture. Idle and abort both park MDC low, pad released.
module mdio_frame_shifter
  import phy_poller_pkg::*;
#(
  parameter int         CLK_DIV  = 10,
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter logic [4:0] STAT_REG = 5'd17
) (
  input  logic        clk_50_max10,
  input  logic        fpga_resetn,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        done_o,
  output logic        ta_err_o,
  output logic [15:0] rd_data_o,
  output logic [5:0]  bit_o,
  output logic        mdc_o,
  input  logic        mdio_in_i,
  output logic        mdio_out_o,
  output logic        mdio_oen_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic               busy_q;
  logic [DIV_W-1:0]   div_q;
  logic               mdc_q;
  logic [5:0]         bit_q;
  logic [CMD_LEN-1:0] cmd_q;
  logic [15:0]        rx_q;
  logic               ta_err_q;
  logic               done_q;
  logic               wrap;
  logic               driving;

  assign wrap    = (div_q == DIV_W'(CLK_DIV - 1));
  assign driving = busy_q && (bit_q < 6'(CMD_END));

  // Divider, bit sequencing and sampling; new bit on MDC fall, sample on rise
  always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
    if (!fpga_resetn) begin
      busy_q   <= 1'b0;
      div_q    <= '0;
      mdc_q    <= 1'b0;
      bit_q    <= '0;
      cmd_q    <= '0;
      rx_q     <= '0;
      ta_err_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        busy_q <= 1'b0;
        div_q  <= '0;
        mdc_q  <= 1'b0;
        bit_q  <= '0;
      end else if (start_i && !busy_q) begin
        busy_q <= 1'b1;
        div_q  <= '0;
        mdc_q  <= 1'b0;
        bit_q  <= '0;
        cmd_q  <= rd_cmd(PHY_ADDR, STAT_REG);
      end else if (busy_q) begin
        if (wrap) begin
          div_q <= '0;
          mdc_q <= ~mdc_q;
          if (!mdc_q) begin
            // rising MDC: capture second TA bit and data bits
            if (bit_q == 6'(DATA_START - 1))
              ta_err_q <= mdio_in_i;
            else if (bit_q >= 6'(DATA_START))
              rx_q <= {rx_q[14:0], mdio_in_i};
          end else begin
            // falling MDC: advance to next bit or close the frame
            if (bit_q == 6'(FRAME_LEN - 1)) begin
              busy_q <= 1'b0;
              bit_q  <= '0;
              done_q <= 1'b1;
            end else begin
              bit_q <= bit_q + 6'd1;
              if (bit_q >= 6'(PRE_LEN))
                cmd_q <= {cmd_q[CMD_LEN-2:0], 1'b0};
            end
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  assign mdc_o      = mdc_q;
  assign mdio_oen_o = ~driving;
  assign mdio_out_o = (driving && (bit_q >= 6'(PRE_LEN))) ? cmd_q[CMD_LEN-1] : 1'b1;
  assign done_o     = done_q;
  assign ta_err_o   = ta_err_q;
  assign rd_data_o  = rx_q;
  assign bit_o      = bit_q;

endmodule

// File: rtl/phy_speed_poller.sv
// Periodic MDIO read of the PHY status register; decodes link/duplex/speed
// into the TSE MAC set_10/set_1000 inputs. Software can park it via hold.
module phy_speed_poller
  import phy_poller_pkg::*;
#(
  parameter int          CLK_DIV        = 10,
  parameter logic [4:0]  PHY_ADDR       = 5'd0,
  parameter logic [4:0]  STAT_REG       = 5'd17,
  parameter logic [23:0] STARTUP_CYCLES = 24'd1_000_000,
  parameter logic [23:0] POLL_CYCLES    = 24'd5_000_000
) (
  input  logic                 clk_50_max10,
  input  logic                 fpga_resetn,
  input  logic                 phy_resetn,
  phy_speed_poller_if.master   bus,
  output logic                 set_10,
  output logic                 set_1000,
  output logic                 link_up,
  output logic                 full_duplex,
  output logic                 status_valid,
  output logic [15:0]          last_status,
  output logic                 rd_err
);

  state_e      state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic        start;
  logic        sh_done;
  logic        sh_ta_err;
  logic [15:0] sh_data;
  logic [5:0]  sh_bit;

  logic        hold_ack_q;
  logic        set_10_q, set_1000_q, link_up_q, full_duplex_q;
  logic        status_valid_q, rd_err_q;
  logic [15:0] last_status_q;

  mdio_frame_shifter #(
    .CLK_DIV  (CLK_DIV),
    .PHY_ADDR (PHY_ADDR),
    .STAT_REG (STAT_REG)
  ) u_shift (
    .clk_50_max10 (clk_50_max10),
    .fpga_resetn  (fpga_resetn),
    .start_i      (start),
    .abort_i      (~phy_resetn),
    .done_o       (sh_done),
    .ta_err_o     (sh_ta_err),
    .rd_data_o    (sh_data),
    .bit_o        (sh_bit),
    .mdc_o        (bus.mdc),
    .mdio_in_i    (bus.mdio_in),
    .mdio_out_o   (bus.mdio_out),
    .mdio_oen_o   (bus.mdio_oen)
  );

  // State and interval timer registers
  always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
    if (!fpga_resetn) begin
      state_q <= ST_WAIT_RST;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next state: timers, hold arbitration, frame field tracking
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    start   = 1'b0;
    if (!phy_resetn) begin
      state_d = ST_WAIT_RST;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_RST: begin
          state_d = ST_STARTUP;
          tmr_d   = '0;
        end
        ST_STARTUP: begin
          if (tmr_q == STARTUP_CYCLES - 24'd1) begin
            state_d = ST_PRE;
            start   = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 24'd1;
          end
        end
        ST_IDLE: begin
          // hold request beats a same-cycle poll expiry
          if (bus.hold_req) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end else if (tmr_q == POLL_CYCLES - 24'd1) begin
            state_d = ST_PRE;
            start   = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 24'd1;
          end
        end
        ST_PRE:  if (sh_bit == 6'(PRE_LEN))    state_d = ST_CMD;
        ST_CMD:  if (sh_bit == 6'(CMD_END))    state_d = ST_TA;
        ST_TA:   if (sh_bit == 6'(DATA_START)) state_d = ST_DATA;
        ST_DATA: if (sh_done)                  state_d = ST_DONE;
        ST_DONE: begin
          state_d = bus.hold_req ? ST_HOLD : ST_IDLE;
          tmr_d   = '0;
        end
        ST_HOLD: begin
          if (!bus.hold_req) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end
        end
        default: state_d = ST_WAIT_RST;
      endcase
    end
  end

  // Hold acknowledge tracks the HOLD state with one clk of registration
  always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
    if (!fpga_resetn) hold_ack_q <= 1'b0;
    else              hold_ack_q <= (state_d == ST_HOLD);
  end

  // Status decode on frame completion; PHY reset clears everything
  always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
    if (!fpga_resetn) begin
      set_10_q       <= 1'b0;
      set_1000_q     <= 1'b0;
      link_up_q      <= 1'b0;
      full_duplex_q  <= 1'b0;
      status_valid_q <= 1'b0;
      rd_err_q       <= 1'b0;
      last_status_q  <= '0;
    end else begin
      status_valid_q <= 1'b0;
      rd_err_q       <= 1'b0;
      if (!phy_resetn) begin
        set_10_q      <= 1'b0;
        set_1000_q    <= 1'b0;
        link_up_q     <= 1'b0;
        full_duplex_q <= 1'b0;
        last_status_q <= '0;
      end else if (state_q == ST_DONE) begin
        if (sh_ta_err) begin
          rd_err_q <= 1'b1;
        end else begin
          status_valid_q <= 1'b1;
          last_status_q  <= sh_data;
          if (sh_data[RESOLVED] && sh_data[LINK]) begin
            link_up_q     <= 1'b1;
            full_duplex_q <= sh_data[DPX];
            case (sh_data[SPD_HI:SPD_LO])
              SPD_10:   begin set_10_q <= 1'b1; set_1000_q <= 1'b0; end
              SPD_100:  begin set_10_q <= 1'b0; set_1000_q <= 1'b0; end
              SPD_1000: begin set_10_q <= 1'b0; set_1000_q <= 1'b1; end
              default:  ; // reserved code: keep current speed
            endcase
          end else begin
            link_up_q     <= 1'b0;
            full_duplex_q <= 1'b0;
            set_10_q      <= 1'b0;
            set_1000_q    <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.hold_ack  = hold_ack_q;
  assign set_10        = set_10_q;
  assign set_1000      = set_1000_q;
  assign link_up       = link_up_q;
  assign full_duplex   = full_duplex_q;
  assign status_valid  = status_valid_q;
  assign rd_err        = rd_err_q;
  assign last_status   = last_status_q;

endmodule

// File: tb/tb_phy_speed_poller.sv
// Bench for phy_speed_poller: MDIO PHY model, speed/link reference model,
// directed hold/reset scenarios and randomized status words.
module tb_phy_speed_poller;

  logic        clk = 1'b0;
  logic        fpga_resetn;
  logic        phy_resetn;
  logic        set_10, set_1000, link_up, full_duplex, status_valid, rd_err;
  logic [15:0] last_status;

  phy_speed_poller_if bus();

  phy_speed_poller #(
    .CLK_DIV        (2),
    .PHY_ADDR       (5'd0),
    .STAT_REG       (5'd17),
    .STARTUP_CYCLES (24'd16),
    .POLL_CYCLES    (24'd200)
  ) dut (
    .clk_50_max10 (clk),
    .fpga_resetn  (fpga_resetn),
    .phy_resetn   (phy_resetn),
    .bus          (bus),
    .set_10       (set_10),
    .set_1000     (set_1000),
    .link_up      (link_up),
    .full_duplex  (full_duplex),
    .status_valid (status_valid),
    .last_status  (last_status),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  localparam logic [45:0] CMD_EXP = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd17};

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // ---------------- PHY model ----------------
  logic [15:0] resp   = 16'h0;
  bit          silent = 1'b0;
  bit          frame_on = 1'b0;
  int          pbit = 0;
  logic [45:0] cap = '0;
  logic [45:0] cap_last = '0;
  logic        prev_mdc = 1'b0;
  logic        prev_oen = 1'b1;

  always @(negedge clk) begin
    if (!fpga_resetn || !phy_resetn) begin
      frame_on    = 1'b0;
      bus.mdio_in = 1'b1;
    end else begin
      if (!frame_on && !bus.mdio_oen && prev_oen) begin
        frame_on = 1'b1;
        pbit     = 0;
        cap      = '0;
      end
      if (frame_on) begin
        if (bus.mdc && !prev_mdc && pbit < 46)
          cap = {cap[44:0], bus.mdio_out};
        if (!bus.mdc && prev_mdc) begin
          pbit++;
          if (pbit == 46) cap_last = cap;
          if (pbit == 64) frame_on = 1'b0;
        end
      end
      if (frame_on && pbit == 47)      bus.mdio_in = silent;
      else if (frame_on && pbit >= 48) bus.mdio_in = silent ? 1'b1 : resp[63-pbit];
      else                             bus.mdio_in = 1'b1;
    end
    prev_mdc = bus.mdc;
    prev_oen = bus.mdio_oen;
  end

  // ---------------- reference model ----------------
  bit          m_link, m_dpx;
  int          m_mbps;       // 0 = no speed selected
  logic [15:0] m_last;

  task automatic model_reset();
    m_link = 0; m_dpx = 0; m_mbps = 0; m_last = 16'h0;
  endtask

  task automatic model_apply(input logic [15:0] d);
    m_last = d;
    if (d[11] && d[10]) begin
      m_link = 1;
      m_dpx  = d[13];
      case (d[15:14])
        2'd0: m_mbps = 10;
        2'd1: m_mbps = 100;
        2'd2: m_mbps = 1000;
        default: ;
      endcase
    end else begin
      m_link = 0; m_dpx = 0; m_mbps = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic wait_pulse(output bit ok, output int n);
    ok = 0; n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (status_valid || rd_err) begin ok = 1; break; end
    end
  endtask

  task automatic check_poll(input string tag, input logic [15:0] d, input bit sil, input bit ok);
    chk({tag, "_seen"}, 48'(ok), 48'd1);
    if (!sil) model_apply(d);
    chk({tag, "_kind"}, {status_valid, rd_err}, sil ? 2'b01 : 2'b10);
    chk({tag, "_outs"}, {link_up, full_duplex, set_10, set_1000, last_status},
        {m_link, m_dpx, m_mbps == 10, m_mbps == 1000, m_last});
    chk({tag, "_excl"}, 48'(set_10 & set_1000), 48'd0);
    chk({tag, "_cmd"}, cap_last, CMD_EXP);
    @(negedge clk);
    chk({tag, "_1pulse"}, {status_valid, rd_err}, 2'b00);
  endtask

  task automatic run_poll(input string tag, input logic [15:0] d, input bit sil);
    bit ok; int n;
    resp = d; silent = sil;
    wait_pulse(ok, n);
    check_poll(tag, d, sil, ok);
  endtask

  task automatic wait_data(input int b);
    int n = 0;
    while (!(frame_on && pbit >= b) && n < 3000) begin @(negedge clk); n++; end
    chk("wait_data", 48'(n < 3000), 48'd1);
  endtask

  task automatic count_to_frame(output int n);
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (!bus.mdio_oen) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok; int n, d_gap, mdc_hi, oen_lo;
    logic [15:0] d; bit sil;

    fpga_resetn = 0; phy_resetn = 0; bus.hold_req = 0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_outs", {bus.mdc, bus.mdio_out, bus.mdio_oen, bus.hold_ack, set_10, set_1000,
                     link_up, full_duplex, status_valid, rd_err, last_status},
        {10'b0110000000, 16'h0});

    // 1: PHY held in reset
    fpga_resetn = 1;
    mdc_hi = 0; oen_lo = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.mdc) mdc_hi++;
      if (!bus.mdio_oen) oen_lo++;
    end
    chk("t1_mdc_hi", 48'(mdc_hi), 48'd0);
    chk("t1_oen_lo", 48'(oen_lo), 48'd0);
    chk("t1_outs", {bus.hold_ack, set_10, set_1000, link_up, full_duplex, status_valid, rd_err,
                    last_status}, 48'h0);

    // 2: first poll after PHY reset release
    resp = 16'hAC00; silent = 0;
    phy_resetn = 1;
    wait_pulse(ok, n);
    chk("t2_latency", 48'(n >= 264 && n <= 280), 48'd1);
    check_poll("t2", 16'hAC00, 0, ok);

    // 3: speed changes
    run_poll("t3_10m",   16'h0C00, 0);
    run_poll("t3_100m",  16'h4C00, 0);
    run_poll("t3_rsvd",  16'hEC00, 0);
    run_poll("t3_down",  16'h0000, 0);
    run_poll("t3_1000h", 16'h8C00, 0);

    // 4: silent PHY; also measure pulse-to-next-frame gap
    silent = 1;
    count_to_frame(d_gap);
    chk("t4_gap", 48'(d_gap >= 198 && d_gap <= 206), 48'd1);
    run_poll("t4_silent", 16'h1234, 1);

    // 5: hold raised during DATA
    resp = 16'h6C00; silent = 0;
    wait_data(50);
    bus.hold_req = 1;
    wait_pulse(ok, n);
    chk("t5_ack_now", 48'(bus.hold_ack), 48'd1);
    check_poll("t5", 16'h6C00, 0, ok);
    mdc_hi = 0; oen_lo = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mdc) mdc_hi++;
      if (!bus.mdio_oen) oen_lo++;
    end
    chk("t5_hold_bus", {bus.hold_ack, 16'(mdc_hi), 16'(oen_lo)}, {1'b1, 32'h0});
    bus.hold_req = 0;
    @(negedge clk);
    chk("t5_ack_drop", 48'(bus.hold_ack), 48'd0);
    resp = 16'h2C00;
    count_to_frame(n);
    chk("t5_resume", 48'(n + 1 >= 199 && n + 1 <= 203), 48'd1);
    run_poll("t5_next", 16'h2C00, 0);

    // 5b: hold coincident with poll timer expiry
    repeat (d_gap - 2) @(negedge clk);
    bus.hold_req = 1;
    oen_lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.mdio_oen) oen_lo++;
    end
    chk("t5b_hold", {bus.hold_ack, 16'(oen_lo)}, {1'b1, 16'h0});
    bus.hold_req = 0;
    run_poll("t5b_next", 16'h8C00, 0);

    // 6: PHY reset mid-DATA
    resp = 16'h4C00;
    wait_data(52);
    phy_resetn = 0;
    @(negedge clk);
    model_reset();
    chk("t6_abort", {bus.mdio_oen, bus.mdc, bus.hold_ack, link_up, full_duplex, set_10, set_1000,
                     last_status}, {7'b1000000, 16'h0});
    repeat (5) @(negedge clk);
    resp = 16'hEC00;
    phy_resetn = 1;
    count_to_frame(n);
    chk("t6_startup", 48'(n >= 15 && n <= 20), 48'd1);
    run_poll("t6_fresh", 16'hEC00, 0);

    // randomized polls
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) != 0) d[11:10] = 2'b11;
      sil = ($urandom_range(0, 7) == 0);
      run_poll($sformatf("rnd%0d", i), d, sil);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
